// File: rtl/punc_mem_responder.sv
// Memory-side responder for the PUnC LC3 control unit. It accepts one request at a time
// over a valid/ready handshake, models a fixed read/write latency, and holds its response until acknowledged.
module punc_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [15:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              direct;
  logic              access;
  logic [CNT_W-1:0]  load_val;
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_in_range;

  // A single-cycle request is serviced straight from the request bus on the accepting
  // edge; longer ones use the fields latched at acceptance.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    accept       = 1'b0;
    load_val     = RD_LOAD;
    direct       = 1'b0;
    access       = 1'b0;
    acc_we       = lat_we;
    acc_addr     = lat_addr;
    acc_wdata    = lat_wdata;
    if (state == S_IDLE) begin
      accept    = req_valid;
      load_val  = req_we ? WR_LOAD : RD_LOAD;
      direct    = (load_val == '0);
      access    = accept && direct;
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else if (state == S_WAIT) begin
      access = (cnt == CNT_ONE);
    end
    acc_in_range = ((acc_addr >> ADDR_W) == 16'd0);
    acc_idx      = acc_addr[ADDR_W-1:0];
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (req_valid) state_nxt = direct ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CNT_ONE) state_nxt = S_RESP;
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  // Request capture, latency counter and the held response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= load_val;
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_ONE;
      end
      if (access) begin
        resp_err <= !acc_in_range;
        if (!acc_in_range) begin
          resp_rdata <= '0;
        end else if (acc_we) begin
          resp_rdata <= acc_wdata;
        end else begin
          resp_rdata <= mem[acc_idx];
        end
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (access && acc_we && acc_in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_punc_mem_responder.sv
// Self-checking bench for punc_mem_responder: table-driven transactions with a response
// scoreboard, plus hand-written stall, reset-abort and back-to-back sequences.
module tb_punc_mem_responder;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [15:0] a_req_addr, a_req_wdata, a_resp_rdata, a_dbg_rdata;
  logic [7:0]  a_dbg_addr;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata, b_dbg_rdata;
  logic [7:0]  b_dbg_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  punc_mem_responder u_a (
    .clk(clk), .rst(rst_a),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .dbg_addr(a_dbg_addr), .dbg_rdata(a_dbg_rdata)
  );

  punc_mem_responder #(.RD_LAT(3), .WR_LAT(3)) u_b (
    .clk(clk), .rst(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .dbg_addr(b_dbg_addr), .dbg_rdata(b_dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: response 0x%0h with empty scoreboard", name, a_resp_rdata);
    end else begin
      e = exp_q.pop_front();
      if (a_resp_rdata !== e.rdata || a_resp_err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got rdata=0x%0h err=%0b expected rdata=0x%0h err=%0b",
                 name, a_resp_rdata, a_resp_err, e.rdata, e.err);
      end
    end
  endtask

  // One complete transaction on DUT A; called at a sample point with resp_ready=1.
  task automatic a_txn(input vec_t v, input string name);
    int   n;
    int   lat;
    exp_t e;
    lat = v.we ? 1 : 2;
    check({name, "_ready_before"}, a_req_ready, 1);
    a_req_we    = v.we;
    a_req_addr  = v.addr;
    a_req_wdata = v.wdata;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    e.rdata = v.rdata;
    e.err   = v.err;
    exp_q.push_back(e);
    a_req_valid = 1'b0;
    check({name, "_ready_after_accept"}, a_req_ready, 0);
    n = 0;
    while (!a_resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, lat - 1);
    pop_compare({name, "_resp"});
    @(posedge clk); #1;
    check({name, "_valid_drop"}, a_resp_valid, 0);
    check({name, "_ready_back"}, a_req_ready, 1);
    if (v.we && (v.addr >> 8) == 16'd0) begin
      a_dbg_addr = v.addr[7:0];
      #1;
      check({name, "_dbg"}, a_dbg_rdata, v.wdata);
    end
  endtask

  vec_t tbl[9];
  vec_t bb[3];

  initial begin
    int   n;
    int   idx;
    int   last;
    int   prev_lat;
    logic acc;
    exp_t e;

    tbl[0] = '{1'b1, 16'h0005, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b1, 16'h0006, 16'h0606, 16'h0606, 1'b0};
    tbl[3] = '{1'b1, 16'h0000, 16'h0A0A, 16'h0A0A, 1'b0};
    tbl[4] = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1};
    tbl[5] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1};
    tbl[6] = '{1'b1, 16'h00FF, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[7] = '{1'b0, 16'h00FF, 16'h0000, 16'hFFFF, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 16'h0A0A, 1'b0};

    bb[0] = '{1'b1, 16'h0002, 16'h0011, 16'h0011, 1'b0};
    bb[1] = '{1'b0, 16'h0002, 16'h0000, 16'h0011, 1'b0};
    bb[2] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_resp_ready = 1'b1; a_dbg_addr = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_resp_ready = 1'b1; b_dbg_addr = '0;
    #2;
    check("rst_req_ready", a_req_ready, 1);
    check("rst_resp_valid", a_resp_valid, 0);
    check("rst_resp_rdata", a_resp_rdata, 0);
    check("rst_resp_err", a_resp_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      a_txn(tbl[i], $sformatf("vec%0d", i));
    end
    a_dbg_addr = 8'h00; #1;
    check("oor_no_alias_mem0", a_dbg_rdata, 16'h0A0A);
    a_dbg_addr = 8'h05; #1;
    check("dbg_mem5", a_dbg_rdata, 16'hBEEF);

    // Stalled read: response must hold while resp_ready is low and new requests are ignored.
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    a_req_we = 1'b0; a_req_addr = 16'h0005; a_req_valid = 1'b1;
    @(posedge clk); #1;
    e.rdata = 16'hBEEF; e.err = 1'b0;
    exp_q.push_back(e);
    a_req_we = 1'b1; a_req_addr = 16'h0006; a_req_wdata = 16'h7777;
    n = 0;
    while (!a_resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_latency", n, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_valid", i), a_resp_valid, 1);
      check($sformatf("stall%0d_rdata", i), a_resp_rdata, 16'hBEEF);
      check($sformatf("stall%0d_ready", i), a_req_ready, 0);
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    pop_compare("stall_resp");
    @(posedge clk); #1;
    check("stall_valid_drop", a_resp_valid, 0);
    check("stall_ready_back", a_req_ready, 1);
    a_dbg_addr = 8'h06; #1;
    check("stall_ignored_write", a_dbg_rdata, 16'h0606);

    // Back-to-back requests with req_valid and resp_ready held high.
    @(posedge clk); #1;
    idx = 0; last = -1; prev_lat = 0;
    a_req_we = bb[0].we; a_req_addr = bb[0].addr; a_req_wdata = bb[0].wdata;
    a_req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && !(idx == 3 && exp_q.size() == 0); cyc++) begin
      if (a_resp_valid) pop_compare($sformatf("b2b_resp_c%0d", cyc));
      acc = a_req_ready && a_req_valid;
      @(posedge clk); #1;
      if (acc) begin
        e.rdata = bb[idx].rdata; e.err = bb[idx].err;
        exp_q.push_back(e);
        if (last >= 0) check($sformatf("b2b_period%0d", idx), cyc - last, prev_lat + 1);
        last = cyc;
        prev_lat = bb[idx].we ? 1 : 2;
        idx++;
        if (idx < 3) begin
          a_req_we = bb[idx].we; a_req_addr = bb[idx].addr; a_req_wdata = bb[idx].wdata;
        end else begin
          a_req_valid = 1'b0;
        end
      end
    end
    check("b2b_all_done", (idx == 3 && exp_q.size() == 0), 1);

    // Reset during WAIT of a 3-cycle write on the second instance.
    @(posedge clk); #1;
    b_req_we = 1'b1; b_req_addr = 16'h0007; b_req_wdata = 16'h5555; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n = 0;
    while (!b_resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_wr_latency", n, 2);
    check("b_wr_rdata", b_resp_rdata, 16'h5555);
    @(posedge clk); #1;
    b_dbg_addr = 8'h07; #1;
    check("b_dbg_prefill", b_dbg_rdata, 16'h5555);
    b_req_wdata = 16'hAAAA; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    check("b_in_wait_ready", b_req_ready, 0);
    check("b_in_wait_valid", b_resp_valid, 0);
    #2 rst_b = 1'b0;
    #1;
    check("b_async_ready", b_req_ready, 1);
    check("b_async_valid", b_resp_valid, 0);
    check("b_async_rdata", b_resp_rdata, 0);
    check("b_async_err", b_resp_err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    check("b_write_dropped", b_dbg_rdata, 16'h5555);
    @(posedge clk); #1;
    b_req_we = 1'b0; b_req_addr = 16'h0007; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n = 0;
    while (!b_resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_rd_latency", n, 2);
    check("b_rd_rdata", b_resp_rdata, 16'h5555);
    @(posedge clk); #1;
    check("b_rd_ready_back", b_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
